// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with tear-free snapshots and anti-ghost dead time.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zeros on digits above digit 0).
module seg7_scan_driver #(
   parameter int CLK_HZ      = 100_000_000,
   parameter int SCAN_HZ     = 1_000,
   parameter int NUM_DIGITS  = 3,
   parameter int DEAD_CYCLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [4*NUM_DIGITS-1:0] i_digits,
   input  logic [NUM_DIGITS-1:0]   i_dp,
   input  logic                    i_load,
   input  logic                    i_blank,
   output logic [7:0]              o_seg,
   output logic [NUM_DIGITS-1:0]   o_an,
   output logic                    o_frame
);

   localparam int SLOT  = CLK_HZ / SCAN_HZ;
   localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT - 1);
   localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [0:0] {
      S_DEAD  = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   // Slot 0 starts in the dead phase unless no dead time is configured.
   localparam state_t S_RESET = (DEAD_CYCLES > 0) ? S_DEAD : S_DRIVE;

   logic [CNT_W-1:0]        cnt_r, cnt_next_s;
   logic [IDX_W-1:0]        idx_r, idx_next_s;
   state_t                  state_r, state_next_s;
   logic                    frame_start_s;

   logic [4*NUM_DIGITS-1:0] pend_digits_r, act_digits_r, eff_digits_s;
   logic [NUM_DIGITS-1:0]   pend_dp_r, act_dp_r, eff_dp_s;
   logic                    pend_valid_r;

   logic [3:0]              digit_s;
   logic                    dp_sel_s;
   logic                    blank_sel_s;
   logic [NUM_DIGITS-1:0]   an_sel_s;
   logic [NUM_DIGITS-1:0]   lz_mask_s;
   logic [7:0]              seg_next_s;
   logic [NUM_DIGITS-1:0]   an_next_s;

   function automatic logic [6:0] seg7_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg7_decode = 7'h40;
         4'd1:    seg7_decode = 7'h79;
         4'd2:    seg7_decode = 7'h24;
         4'd3:    seg7_decode = 7'h30;
         4'd4:    seg7_decode = 7'h19;
         4'd5:    seg7_decode = 7'h12;
         4'd6:    seg7_decode = 7'h02;
         4'd7:    seg7_decode = 7'h78;
         4'd8:    seg7_decode = 7'h00;
         4'd9:    seg7_decode = 7'h10;
         default: seg7_decode = 7'h3F;
      endcase
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // Bit k set when digit k and every digit above it are zero; digit 0 never blanks.
   function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(input logic [4*NUM_DIGITS-1:0] d);
      logic run;
      leading_zero_mask = {NUM_DIGITS{1'b0}};
      run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         run = run & (d[k*4 +: 4] == 4'd0);
         leading_zero_mask[k] = run;
      end
   endfunction
`endif

   // Slot counter and digit index advance.
   always_comb begin
      cnt_next_s = cnt_r + CNT_W'(1);
      idx_next_s = idx_r;
      if (cnt_r == CNT_LAST) begin
         cnt_next_s = {CNT_W{1'b0}};
         if (idx_r == IDX_LAST) begin
            idx_next_s = {IDX_W{1'b0}};
         end else begin
            idx_next_s = idx_r + IDX_W'(1);
         end
      end else begin
         idx_next_s = idx_r;
      end
   end

   // Scan position registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_r <= {CNT_W{1'b0}};
         idx_r <= {IDX_W{1'b0}};
      end else begin
         cnt_r <= cnt_next_s;
         idx_r <= idx_next_s;
      end
   end

   // Slot phase next-state, tracking where the next counter value lands.
   always_comb begin
      state_next_s = S_DEAD;
      if (cnt_next_s < CNT_DEAD) begin
         state_next_s = S_DEAD;
      end else begin
         state_next_s = S_DRIVE;
      end
   end

   // Slot phase state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_r <= S_RESET;
      end else begin
         state_r <= state_next_s;
      end
   end

   assign frame_start_s = (cnt_r == {CNT_W{1'b0}}) && (idx_r == {IDX_W{1'b0}});

   // Values shown this cycle: on the frame-start cycle the incoming snapshot is used immediately.
   always_comb begin
      eff_digits_s = act_digits_r;
      eff_dp_s     = act_dp_r;
      if (frame_start_s) begin
         if (i_load) begin
            eff_digits_s = i_digits;
            eff_dp_s     = i_dp;
         end else if (pend_valid_r) begin
            eff_digits_s = pend_digits_r;
            eff_dp_s     = pend_dp_r;
         end else begin
            eff_digits_s = act_digits_r;
            eff_dp_s     = act_dp_r;
         end
      end else begin
         eff_digits_s = act_digits_r;
         eff_dp_s     = act_dp_r;
      end
   end

   // Pending/active snapshot registers; active only changes at a frame boundary.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pend_digits_r <= {(4*NUM_DIGITS){1'b0}};
         pend_dp_r     <= {NUM_DIGITS{1'b0}};
         pend_valid_r  <= 1'b0;
         act_digits_r  <= {(4*NUM_DIGITS){1'b0}};
         act_dp_r      <= {NUM_DIGITS{1'b0}};
      end else if (frame_start_s) begin
         act_digits_r  <= eff_digits_s;
         act_dp_r      <= eff_dp_s;
         pend_valid_r  <= 1'b0;
      end else if (i_load) begin
         pend_digits_r <= i_digits;
         pend_dp_r     <= i_dp;
         pend_valid_r  <= 1'b1;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   assign lz_mask_s = leading_zero_mask(eff_digits_s);
`else
   assign lz_mask_s = {NUM_DIGITS{1'b0}};
`endif

   // Select the current digit, its dp, blank flag and anode pattern.
   always_comb begin
      digit_s     = 4'd0;
      dp_sel_s    = 1'b0;
      blank_sel_s = 1'b0;
      an_sel_s    = {NUM_DIGITS{1'b1}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_r == IDX_W'(k)) begin
            digit_s     = eff_digits_s[k*4 +: 4];
            dp_sel_s    = eff_dp_s[k];
            blank_sel_s = lz_mask_s[k];
            an_sel_s[k] = 1'b0;
         end else begin
            an_sel_s[k] = 1'b1;
         end
      end
   end

   // Pin values for the next cycle.
   always_comb begin
      seg_next_s = 8'hFF;
      an_next_s  = {NUM_DIGITS{1'b1}};
      if (!i_blank && (state_r == S_DRIVE)) begin
         an_next_s = an_sel_s;
         if (blank_sel_s) begin
            seg_next_s = {~dp_sel_s, 7'h7F};
         end else begin
            seg_next_s = {~dp_sel_s, seg7_decode(digit_s)};
         end
      end else begin
         seg_next_s = 8'hFF;
         an_next_s  = {NUM_DIGITS{1'b1}};
      end
   end

   // Registered display outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_seg   <= 8'hFF;
         o_an    <= {NUM_DIGITS{1'b1}};
         o_frame <= 1'b0;
      end else begin
         o_seg   <= seg_next_s;
         o_an    <= an_next_s;
         o_frame <= frame_start_s;
      end
   end

endmodule
